mag_cmp_pipe: RTL
=================

Name: mag_cmp_pipe

Overview:
- Pipelined, streaming magnitude comparator; next generation of the combinational SPLIT-ary tree comparator.
- Compares `val` against `rfr` per transaction, per-transaction signed/unsigned mode, outputs greater/less/equal flags.
- Optional register stage after every tree level for high-fmax datapaths; valid/ready handshake with backpressure; user sideband carried in lockstep.
- Sits between address/limit register files and PMP/range-check or sorter logic.

Parameters:
- WIDTH, 32, operand width in bits (>=1).
- SPLIT, 2, tree radix: number of children per node (>=2).
- PIPE, 1:
  - 0: single output register only.
  - 1: register after every tree level.
- USER, 1, width of the sideband tag passed through unchanged (>=1).

Ports:
- clk, input, 1, clock; all state on rising edge.
- rst, input, 1, reset; synchronous, active-high.
- s_vld, input, 1, input transaction valid.
- s_rdy, output, 1, input ready.
- s_sgn, input, 1, 1 = operands are two's complement, 0 = unsigned.
- s_val, input, WIDTH, value.
- s_rfr, input, WIDTH, reference.
- s_usr, input, USER, sideband tag.
- m_vld, output, 1, result valid.
- m_rdy, input, 1, downstream ready.
- m_grt, output, 1, val > rfr.
- m_lst, output, 1, val < rfr.
- m_eql, output, 1, val == rfr.
- m_usr, output, USER, tag of the result's transaction.

Behaviour:
- Levels: L = smallest integer with SPLIT**L >= WIDTH; POWER = SPLIT**L.
- Preprocessing (combinational, at input):
  - If s_sgn = 1, invert the MSB of both operands.
  - Then zero-extend both to POWER bits.
  - Padding bits compare equal and must not affect the result.
- Tree node: combines SPLIT child (grt, lst) pairs, most significant child first.
  - grt = OR over i of (grt_i AND no higher child has grt or lst).
  - lst is formed the same way.
  - Leaf level: grt = v & ~r, lst = ~v & r, per bit.
- Equality flag: m_eql = ~m_grt & ~m_lst. It is never stored separately.
- Invariant: m_grt and m_lst are never both 1.
- Latency (s_vld & s_rdy to the corresponding m_vld):
  - PIPE = 0: 1 cycle.
  - PIPE = 1: max(L, 1) cycles.
  - WIDTH = 1 gives L = 0: a single leaf plus the output register, latency 1.
- Handshake:
  - en = m_rdy | ~m_vld.
  - s_rdy = en. This is combinational from m_rdy and is the only comb path input to output.
  - When en = 1, all pipeline stages advance. A stage valid bit loads the upstream valid, so bubbles are carried, not collapsed.
  - When en = 0, all stages hold, including data, valid and tag.
  - m_vld, m_grt, m_lst and m_usr are held stable while m_vld & ~m_rdy.
  - The transfer rule is unchanged for multi-stage pipelines: the whole pipe stalls as one unit.
- Data registers may load unconditionally when en = 1, regardless of valid. Outputs are only meaningful when m_vld = 1.
- Reset (rst = 1 at a clock edge):
  - All stage valid bits clear to 0.
  - m_vld = 0, m_grt = 0, m_lst = 0, m_usr = 0, hence m_eql = 1.
  - s_rdy = 1 after reset, because m_vld = 0.
  - Reset mid-stream discards all in-flight transactions. Nothing is emitted afterwards for them.
- Simultaneous input accept and output accept in one cycle is legal. Throughput is 1 result per cycle with m_rdy held at 1.
- s_sgn is sampled with its transaction and applies only to it. Mixed modes back-to-back are legal.

Test Plan:
- Unsigned equality-edge directed case, WIDTH=32, SPLIT=2, PIPE=1 (L=5):
  - Stimulus: s_val=0x8000_0000, s_rfr=0x7FFF_FFFF, s_sgn=0.
  - Response: m_grt=1, m_lst=0, exactly 5 cycles after accept; m_usr equals the tag sent.
- Signed mode, same operands with s_sgn=1:
  - Response: m_grt=0, m_lst=1.
  - Then s_val=s_rfr=0xFFFF_FFFF gives m_eql=1.
- Non-power width, WIDTH=5, SPLIT=3 (POWER=9, L=2):
  - Sweep all 32x32 operand pairs in both modes.
  - Compare against a reference model: zero wrong flags, no grt&lst overlap.
- Backpressure:
  - Stream 20 random transactions with m_rdy toggling on a pseudo-random pattern.
  - Results arrive in order, none lost or duplicated.
  - Outputs remain stable during every stall cycle; s_rdy=0 exactly when m_vld=1 and m_rdy=0.
- Reset mid-stream:
  - Accept 3 transactions, assert rst for 1 cycle before any emerges.
  - m_vld=0, m_grt=m_lst=0, m_usr=0 at the next edge; none of the 3 results ever appear.
- Full throughput, PIPE=0 and PIPE=1:
  - With m_rdy=1 and s_vld=1 continuously for 100 cycles, 100 results emerge on consecutive cycles.
  - The first result appears at latency 1 and L respectively.

Source files
------------

// File: rtl/mag_cmp_pipe.sv
// mag_cmp_pipe: streaming magnitude comparator built as a SPLIT-ary reduction tree.
//
// Compares s_val against s_rfr per transaction, unsigned or two's complement
// (s_sgn), and reports greater / less / equal. With PIPE=1 a register follows
// every tree level; with PIPE=0 only the output register exists. All stages
// advance together on en = m_rdy | ~m_vld, so a stall freezes the whole pipe.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   s_vld/s_rdy           input handshake (s_rdy is combinational from m_rdy)
//   s_sgn, s_val, s_rfr   mode and operands
//   s_usr                 sideband tag, carried alongside the transaction
//   m_vld/m_rdy           output handshake
//   m_grt, m_lst, m_eql   val > rfr, val < rfr, val == rfr
//   m_usr                 tag of the transaction on the output
module mag_cmp_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SPLIT = 2,
    parameter int unsigned PIPE  = 1,
    parameter int unsigned USER  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_vld,
    output logic             s_rdy,
    input  logic             s_sgn,
    input  logic [WIDTH-1:0] s_val,
    input  logic [WIDTH-1:0] s_rfr,
    input  logic [USER-1:0]  s_usr,
    output logic             m_vld,
    input  logic             m_rdy,
    output logic             m_grt,
    output logic             m_lst,
    output logic             m_eql,
    output logic [USER-1:0]  m_usr
);

    function automatic int unsigned calc_levels(input int unsigned w, input int unsigned s);
        int unsigned p;
        int unsigned n;
        p = 1;
        n = 0;
        while (p < w) begin
            p = p * s;
            n = n + 1;
        end
        return n;
    endfunction

    function automatic int unsigned ipow(input int unsigned b, input int unsigned e);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < e; i++) begin
            r = r * b;
        end
        return r;
    endfunction

    localparam int unsigned L     = calc_levels(WIDTH, SPLIT);
    localparam int unsigned POWER = ipow(SPLIT, L);
    // Number of register stages between input and output (the last is the output register).
    localparam int unsigned NS    = (PIPE != 0 && L > 0) ? L : 1;

    logic en;
    logic fin_g, fin_l;

    assign en    = m_rdy | ~m_vld;
    assign s_rdy = en;

    // Flipping the sign bit maps two's complement order onto unsigned order.
    // Zero padding yields equal leaves that never decide a node.
    logic [WIDTH-1:0] val_m, rfr_m;
    logic [POWER-1:0] val_x, rfr_x;

    always_comb begin
        val_m = s_val;
        rfr_m = s_rfr;
        if (s_sgn) begin
            val_m[WIDTH-1] = ~s_val[WIDTH-1];
            rfr_m[WIDTH-1] = ~s_rfr[WIDTH-1];
        end
        val_x            = '0;
        rfr_x            = '0;
        val_x[WIDTH-1:0] = val_m;
        rfr_x[WIDTH-1:0] = rfr_m;
    end

    for (genvar k = 0; k <= L; k++) begin : g_lvl
        localparam int unsigned N = POWER / ipow(SPLIT, k);

        logic [N-1:0] cmb_g, cmb_l;

        if (k == 0) begin : g_leaf
            assign cmb_g = val_x & ~rfr_x;
            assign cmb_l = ~val_x & rfr_x;
        end else begin : g_node
            always_comb begin
                logic hit;
                hit   = 1'b0;
                cmb_g = '0;
                cmb_l = '0;
                for (int j = 0; j < int'(N); j++) begin
                    hit = 1'b0;
                    // The most significant child that differs decides the node.
                    for (int i = int'(SPLIT) - 1; i >= 0; i--) begin
                        if (!hit) begin
                            cmb_g[j] = g_lvl[k-1].g_fwd.fwd_g[j * int'(SPLIT) + i];
                            cmb_l[j] = g_lvl[k-1].g_fwd.fwd_l[j * int'(SPLIT) + i];
                            hit      = cmb_g[j] | cmb_l[j];
                        end
                    end
                end
            end
        end

        if (k < L) begin : g_fwd
            logic [N-1:0] fwd_g, fwd_l;
            if (PIPE != 0 && k > 0) begin : g_reg
                logic [N-1:0] grt_d, grt_q, lst_d, lst_q;
                always_comb begin
                    grt_d = en ? cmb_g : grt_q;
                    lst_d = en ? cmb_l : lst_q;
                end
                always_ff @(posedge clk) begin
                    grt_q <= grt_d;
                    lst_q <= lst_d;
                end
                assign fwd_g = grt_q;
                assign fwd_l = lst_q;
            end else begin : g_wire
                assign fwd_g = cmb_g;
                assign fwd_l = cmb_l;
            end
        end else begin : g_top
            assign fin_g = cmb_g[0];
            assign fin_l = cmb_l[0];
        end
    end

    // Valid and tag travel in lockstep with the tree stages; bubbles are kept.
    logic [NS-1:0]   vld_d, vld_q;
    logic [USER-1:0] usr_d [NS];
    logic [USER-1:0] usr_q [NS];
    logic            grt_d, grt_q, lst_d, lst_q;

    always_comb begin
        vld_d = vld_q;
        usr_d = usr_q;
        grt_d = grt_q;
        lst_d = lst_q;
        if (en) begin
            vld_d[0] = s_vld;
            usr_d[0] = s_usr;
            for (int s = 1; s < int'(NS); s++) begin
                vld_d[s] = vld_q[s-1];
                usr_d[s] = usr_q[s-1];
            end
            grt_d = fin_g;
            lst_d = fin_l;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int s = 0; s < int'(NS); s++) begin
                usr_q[s] <= '0;
            end
            grt_q <= 1'b0;
            lst_q <= 1'b0;
        end else begin
            vld_q <= vld_d;
            usr_q <= usr_d;
            grt_q <= grt_d;
            lst_q <= lst_d;
        end
    end

    assign m_vld = vld_q[NS-1];
    assign m_usr = usr_q[NS-1];
    assign m_grt = grt_q;
    assign m_lst = lst_q;
    assign m_eql = ~grt_q & ~lst_q;

endmodule
